// File: rtl/fpu_pkg.sv
// Shared single-precision float types, dispatcher state encoding and helpers
// for the FMA operand dispatcher.
package fpu_pkg;

  localparam int unsigned FP      = 32;
  localparam int unsigned EXPBITS = 8;
  localparam int unsigned MANBITS = 23;

  typedef struct packed {
    logic               sign;
    logic [EXPBITS-1:0] exponent;
    logic [MANBITS-1:0] mantissa;
  } float_sp;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StResult,
    StGap
  } disp_state_e;

  // Zero magnitude regardless of sign.
  function automatic logic is_zero(input float_sp f);
    return (f.exponent == '0) && (f.mantissa == '0);
  endfunction

endpackage

// File: rtl/fpu_pair_fifo.sv
// DEPTH-entry synchronous FIFO holding operand pairs. A push while full is
// accepted only when a pop happens in the same cycle.
module fpu_pair_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fma_operand_dispatcher.sv
// Buffers host operand pairs and issues them one at a time to an FMA unit,
// returning answer and flags on a valid/ready port. Option: FMA_ZERO_BYPASS_EN.
module fma_operand_dispatcher
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned REQ_GAP = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid_in,
  output logic          op_ready_out,
  input  logic [FP-1:0] op_a_in,
  input  logic [FP-1:0] op_b_in,
  output logic [FP-1:0] float_0_out,
  output logic [FP-1:0] float_1_out,
  output logic          float_0_req_out,
  output logic          float_1_req_out,
  output logic          float_0_busy_out,
  output logic          float_1_busy_out,
  input  logic [FP-1:0] fma_answer_in,
  input  logic          fma_ready_in,
  input  logic          fma_overflow_in,
  input  logic          fma_underflow_in,
  output logic          res_valid_out,
  input  logic          res_ready_in,
  output logic [FP-1:0] res_out,
  output logic          res_overflow_out,
  output logic          res_underflow_out,
  output logic          res_timeout_out,
  output logic          err_zero_out
);

  localparam int unsigned GapW = $clog2(REQ_GAP + 2);

  disp_state_e     state_q, state_d;
  float_sp         f0_q, f0_d, f1_q, f1_d;
  float_sp         pop_a, pop_b;
  logic [3:0]      wait_cnt_q, wait_cnt_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic [FP-1:0]   res_q, res_d;
  logic            res_ov_q, res_ov_d;
  logic            res_un_q, res_un_d;
  logic            res_to_q, res_to_d;
  logic            err_zero_q, err_zero_d;
  logic            ready_prev_q;
  logic            rdy_en_q;
  logic            ready_rise;
  logic            pair_zero;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2*FP-1:0] fifo_rdata;

  // Ready is held low through reset and the first cycle after it.
  assign op_ready_out = rdy_en_q & ~fifo_full;
  assign fifo_push    = op_valid_in & op_ready_out;

  fpu_pair_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * FP)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({op_a_in, op_b_in}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pop_a      = float_sp'(fifo_rdata[2*FP-1:FP]);
  assign pop_b      = float_sp'(fifo_rdata[FP-1:0]);
  assign pair_zero  = is_zero(pop_a) | is_zero(pop_b);
  assign ready_rise = fma_ready_in & ~ready_prev_q;

  always_comb begin
    state_d    = state_q;
    fifo_pop   = 1'b0;
    f0_d       = f0_q;
    f1_d       = f1_q;
    wait_cnt_d = wait_cnt_q;
    res_d      = res_q;
    res_ov_d   = res_ov_q;
    res_un_d   = res_un_q;
    res_to_d   = res_to_q;
    err_zero_d = err_zero_q;
    // Cycles since the last ISSUE, saturating once the gap is satisfied.
    gap_cnt_d  = (gap_cnt_q >= GapW'(REQ_GAP)) ? gap_cnt_q : gap_cnt_q + GapW'(1);

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (pair_zero) begin
`ifdef FMA_ZERO_BYPASS_EN
            f0_d     = pop_a;
            f1_d     = pop_b;
            res_d    = {pop_a.sign ^ pop_b.sign, {(FP-1){1'b0}}};
            res_ov_d = 1'b0;
            res_un_d = 1'b0;
            res_to_d = 1'b0;
            state_d  = StResult;
`else
            err_zero_d = 1'b1;
`endif
          end else begin
            f0_d    = pop_a;
            f1_d    = pop_b;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        wait_cnt_d = 4'd1;
        gap_cnt_d  = GapW'(1);
        state_d    = StWait;
      end
      StWait: begin
        // A fresh answer beats a simultaneous timeout.
        if (ready_rise) begin
          res_d    = fma_answer_in;
          res_ov_d = fma_overflow_in;
          res_un_d = fma_underflow_in;
          res_to_d = 1'b0;
          state_d  = StResult;
        end else if (wait_cnt_q == 4'(TIMEOUT)) begin
          res_d    = '0;
          res_ov_d = 1'b0;
          res_un_d = 1'b0;
          res_to_d = 1'b1;
          state_d  = StResult;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      StResult: begin
        if (res_ready_in) begin
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_cnt_q >= GapW'(REQ_GAP)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      f0_q         <= '0;
      f1_q         <= '0;
      wait_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      res_q        <= '0;
      res_ov_q     <= 1'b0;
      res_un_q     <= 1'b0;
      res_to_q     <= 1'b0;
      err_zero_q   <= 1'b0;
      ready_prev_q <= 1'b0;
      rdy_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      f0_q         <= f0_d;
      f1_q         <= f1_d;
      wait_cnt_q   <= wait_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      res_q        <= res_d;
      res_ov_q     <= res_ov_d;
      res_un_q     <= res_un_d;
      res_to_q     <= res_to_d;
      err_zero_q   <= err_zero_d;
      ready_prev_q <= fma_ready_in;
      rdy_en_q     <= 1'b1;
    end
  end

  assign float_0_out       = f0_q;
  assign float_1_out       = f1_q;
  assign float_0_req_out   = (state_q == StIssue);
  assign float_1_req_out   = (state_q == StIssue);
  assign float_0_busy_out  = (state_q == StWait);
  assign float_1_busy_out  = (state_q == StWait);
  assign res_valid_out     = (state_q == StResult);
  assign res_out           = res_q;
  assign res_overflow_out  = res_ov_q;
  assign res_underflow_out = res_un_q;
  assign res_timeout_out   = res_to_q;
  assign err_zero_out      = err_zero_q;

endmodule

// File: tb/tb_fma_operand_dispatcher.sv
// Self-checking bench: table of operand pairs, a behavioural FMA responder and a
// result scoreboard, plus hand sequences for backpressure, zero pairs and reset.
`timescale 1ns/1ps
module tb_fma_operand_dispatcher;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned REQ_GAP = 6;
  localparam int          NVEC    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid_in = 1'b0;
  logic        op_ready_out;
  logic [31:0] op_a_in = '0, op_b_in = '0;
  logic [31:0] float_0_out, float_1_out;
  logic        float_0_req_out, float_1_req_out, float_0_busy_out, float_1_busy_out;
  logic [31:0] fma_answer_in = '0;
  logic        fma_ready_in = 1'b0, fma_overflow_in = 1'b0, fma_underflow_in = 1'b0;
  logic        res_valid_out, res_ready_in = 1'b1;
  logic [31:0] res_out;
  logic        res_overflow_out, res_underflow_out, res_timeout_out, err_zero_out;

  always #5 clk = ~clk;

  fma_operand_dispatcher #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .REQ_GAP (REQ_GAP)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .op_valid_in       (op_valid_in),
    .op_ready_out      (op_ready_out),
    .op_a_in           (op_a_in),
    .op_b_in           (op_b_in),
    .float_0_out       (float_0_out),
    .float_1_out       (float_1_out),
    .float_0_req_out   (float_0_req_out),
    .float_1_req_out   (float_1_req_out),
    .float_0_busy_out  (float_0_busy_out),
    .float_1_busy_out  (float_1_busy_out),
    .fma_answer_in     (fma_answer_in),
    .fma_ready_in      (fma_ready_in),
    .fma_overflow_in   (fma_overflow_in),
    .fma_underflow_in  (fma_underflow_in),
    .res_valid_out     (res_valid_out),
    .res_ready_in      (res_ready_in),
    .res_out           (res_out),
    .res_overflow_out  (res_overflow_out),
    .res_underflow_out (res_underflow_out),
    .res_timeout_out   (res_timeout_out),
    .err_zero_out      (err_zero_out)
  );

  // delay: WAIT cycle in which the responder raises ready; 0 = never.
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ans;
    logic        ov;
    logic        un;
    int          delay;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ov;
    logic        un;
    logic        to;
    int          lat;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t exp_q [$];
  int   n_vec = 0;
  int   n_bad = 0;

  int   req_count = 0;
  int   viol_width = 0, viol_gap = 0, viol_pair = 0, viol_stab = 0, viol_busy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  function automatic int find_vec(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].a == a && vecs[i].b == b) return i;
    end
    return -1;
  endfunction

  function automatic exp_t expect_of(input vec_t v);
    exp_t e;
    logic to;
    to    = (v.delay == 0) || (v.delay > int'(TIMEOUT));
    e.res = to ? 32'h0 : v.ans;
    e.ov  = to ? 1'b0 : v.ov;
    e.un  = to ? 1'b0 : v.un;
    e.to  = to;
    e.lat = to ? int'(TIMEOUT) + 1 : v.delay + 1;
    return e;
  endfunction

  // Behavioural FMA: raises ready 'delay' cycles after the request, holds it two cycles.
  int   mdl_cnt = 0, mdl_drop = 0, mdl_idx = -1;
  logic mdl_armed = 1'b0;
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      fma_ready_in = 1'b0;
      mdl_armed    = 1'b0;
      mdl_drop     = 0;
    end else begin
      if (mdl_drop > 0) begin
        mdl_drop--;
        if (mdl_drop == 0) fma_ready_in = 1'b0;
      end
      if (float_0_req_out) begin
        mdl_idx   = find_vec(float_0_out, float_1_out);
        mdl_armed = (mdl_idx >= 0) && (vecs[mdl_idx].delay > 0);
        if (mdl_armed) mdl_cnt = vecs[mdl_idx].delay;
      end else if (mdl_armed) begin
        mdl_cnt--;
        if (mdl_cnt == 0) begin
          fma_answer_in    = vecs[mdl_idx].ans;
          fma_overflow_in  = vecs[mdl_idx].ov;
          fma_underflow_in = vecs[mdl_idx].un;
          fma_ready_in     = 1'b1;
          mdl_drop         = 2;
          mdl_armed        = 1'b0;
        end
      end
    end
  end

  // Protocol monitor and scoreboard, sampled mid-cycle after the drivers settle.
  int          cyc = 0, last_req = -100, lat_meas = 0;
  logic        req_prev = 1'b0, valid_prev = 1'b0, hold_active = 1'b0;
  logic [63:0] op_hold = '0;
  exp_t        mon_e;
  always begin
    @(negedge clk);
    #2;
    cyc++;
    if (rst) begin
      last_req    = -100;
      req_prev    = 1'b0;
      valid_prev  = 1'b0;
      hold_active = 1'b0;
    end else begin
      if (float_0_req_out != float_1_req_out) viol_pair++;
      if (float_0_busy_out != float_1_busy_out) viol_pair++;
      if (float_0_busy_out && float_0_req_out) viol_busy++;
      if (float_0_req_out) begin
        req_count++;
        if (req_prev) viol_width++;
        if (cyc - last_req < int'(REQ_GAP) + 1) viol_gap++;
        last_req    = cyc;
        op_hold     = {float_0_out, float_1_out};
        hold_active = 1'b1;
      end else if (hold_active && (float_0_busy_out || res_valid_out)) begin
        if ({float_0_out, float_1_out} != op_hold) viol_stab++;
      end else begin
        hold_active = 1'b0;
      end
      if (res_valid_out && !valid_prev) lat_meas = cyc - last_req;
      if (res_valid_out && res_ready_in) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_result at %0t: got %h, expected none", $time, res_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("res_out", res_out, mon_e.res);
          check("res_flags{ov,un,to}",
                {29'b0, res_overflow_out, res_underflow_out, res_timeout_out},
                {29'b0, mon_e.ov, mon_e.un, mon_e.to});
          if (mon_e.lat >= 0) check("req_to_valid_latency", 32'(lat_meas), 32'(mon_e.lat));
        end
      end
      valid_prev = res_valid_out;
      req_prev   = float_0_req_out;
    end
  end

  // Called just after a falling edge; returns just after a falling edge.
  task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input exp_t e,
                           input bit want_res);
    int n = 0;
    op_valid_in = 1'b1;
    op_a_in     = a;
    op_b_in     = b;
    while (!op_ready_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready_out) begin
      n_vec++;
      n_bad++;
      $display("FAIL push_accept: op_ready_out stayed 0, expected 1 within 200 cycles");
    end else begin
      @(posedge clk);
      if (want_res) exp_q.push_back(e);
      @(negedge clk);
    end
    op_valid_in = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d results outstanding, expected 0", name, exp_q.size());
    end
    repeat (REQ_GAP + 2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   rc0;
    int   n;
    exp_t e;

    vecs[0] = '{32'h3f800000, 32'h3f800000, 32'h3f800000, 1'b0, 1'b0, 4};
    vecs[1] = '{32'h41700000, 32'hc1a00000, 32'hc3960000, 1'b0, 1'b0, 1};
    vecs[2] = '{32'hc1d00000, 32'h41f80000, 32'hc4498000, 1'b0, 1'b0, 3};
    vecs[3] = '{32'h7f000000, 32'h7f000000, 32'h7f800000, 1'b1, 1'b0, 2};
    vecs[4] = '{32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 5};
    vecs[5] = '{32'h40000000, 32'h40400000, 32'h40c00000, 1'b0, 1'b0, 8};
    vecs[6] = '{32'h40800000, 32'h40800000, 32'h41800000, 1'b0, 1'b0, 0};
    vecs[7] = '{32'h40a00000, 32'h40a00000, 32'h41c80000, 1'b0, 1'b0, 9};

    // Reset values.
    #1;
    check("rst_op_ready", {31'b0, op_ready_out}, 32'h0);
    check("rst_req", {30'b0, float_0_req_out, float_1_req_out}, 32'h0);
    check("rst_busy", {30'b0, float_0_busy_out, float_1_busy_out}, 32'h0);
    check("rst_res_valid", {31'b0, res_valid_out}, 32'h0);
    check("rst_res_out", res_out, 32'h0);
    check("rst_float_0", float_0_out, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single pair: one request pulse, answer in WAIT cycle 4.
    rc0 = req_count;
    push_pair(vecs[0].a, vecs[0].b, expect_of(vecs[0]), 1'b1);
    wait_drain("drain_single");
    check("single_req_pulses", 32'(req_count - rc0), 32'd1);

    // Table sweep back-to-back: ordering, flags, timeout, answer-vs-timeout tie, late edge.
    for (int i = 1; i < NVEC; i++) begin
      push_pair(vecs[i].a, vecs[i].b, expect_of(vecs[i]), 1'b1);
    end
    wait_drain("drain_table");

    // Backpressure: DEPTH+1 pairs with the result port stalled.
    res_ready_in = 1'b0;
    for (int i = 1; i <= int'(DEPTH) + 1; i++) begin
      push_pair(vecs[i].a, vecs[i].b, expect_of(vecs[i]), 1'b1);
    end
    check("full_op_ready", {31'b0, op_ready_out}, 32'h0);
    n = 0;
    while (!res_valid_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    check("stalled_res_valid", {31'b0, res_valid_out}, 32'h1);
    check("stalled_res_out", res_out, vecs[1].ans);
    check("stalled_still_full", {31'b0, op_ready_out}, 32'h0);
    res_ready_in = 1'b1;
    wait_drain("drain_backpressure");
    check("drained_op_ready", {31'b0, op_ready_out}, 32'h1);

    // Zero-magnitude pair.
    rc0 = req_count;
`ifdef FMA_ZERO_BYPASS_EN
    e = '{32'h80000000, 1'b0, 1'b0, 1'b0, -1};
    push_pair(32'h80000000, 32'h3f800000, e, 1'b1);
    wait_drain("drain_zero_bypass");
    check("zero_err_flag", {31'b0, err_zero_out}, 32'h0);
`else
    e = '{32'h0, 1'b0, 1'b0, 1'b0, -1};
    push_pair(32'h80000000, 32'h3f800000, e, 1'b0);
    repeat (20) @(negedge clk);
    check("zero_err_flag", {31'b0, err_zero_out}, 32'h1);
    check("zero_res_valid", {31'b0, res_valid_out}, 32'h0);
`endif
    check("zero_req_pulses", 32'(req_count - rc0), 32'd0);

    // Reset while waiting on an answer that never comes.
    push_pair(vecs[6].a, vecs[6].b, expect_of(vecs[6]), 1'b1);
    n = 0;
    while (!float_0_busy_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("busy_before_reset", {31'b0, float_0_busy_out}, 32'h1);
    #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("midrst_req", {30'b0, float_0_req_out, float_1_req_out}, 32'h0);
    check("midrst_busy", {30'b0, float_0_busy_out, float_1_busy_out}, 32'h0);
    check("midrst_res_valid", {31'b0, res_valid_out}, 32'h0);
    check("midrst_op_ready", {31'b0, op_ready_out}, 32'h0);
    check("midrst_err_zero", {31'b0, err_zero_out}, 32'h0);
    check("midrst_float_1", float_1_out, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_res_valid", {31'b0, res_valid_out}, 32'h0);
    push_pair(vecs[0].a, vecs[0].b, expect_of(vecs[0]), 1'b1);
    wait_drain("drain_after_reset");

    // Protocol invariants accumulated by the monitor.
    check("req_width_violations", 32'(viol_width), 32'd0);
    check("req_gap_violations", 32'(viol_gap), 32'd0);
    check("req_busy_pair_violations", 32'(viol_pair), 32'd0);
    check("req_during_busy_violations", 32'(viol_busy), 32'd0);
    check("operand_stability_violations", 32'(viol_stab), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
